// File: rtl/cfg_seq_loader.sv
// cfg_seq_loader: streams ROM entries to a byte-level I2C write master, one 3-byte transaction per entry.
// Define CFG_PAUSE_EN to build the post-preamble pause state and its counter.
module cfg_seq_loader #(
  parameter int MEM_DEPTH    = 326,
  parameter int MEM_WIDTH    = 24,
  parameter int DATA_WIDTH   = 8,
  parameter int CYCLES       = MEM_WIDTH / DATA_WIDTH,
  parameter int PAUSE_IDX    = 2,
  parameter int PAUSE_CYCLES = 37_500_000,
  parameter int ADDR_W       = $clog2(MEM_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  mem_rd_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  input  logic [MEM_WIDTH-1:0]  mem_data_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_first_o,
  output logic                  m_last_o,
  input  logic                  i2c_busy_i,
  input  logic                  i2c_nack_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_LOAD     = 3'd2,
    S_SEND     = 3'd3,
    S_WAIT_TXN = 3'd4,
    S_PAUSE    = 3'd5,
    S_DONE     = 3'd6,
    S_ERROR    = 3'd7
  } state_e;

  localparam int BCNT_W = $clog2(CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(CYCLES - 1);

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      idx_q, idx_d;
  logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
  logic [MEM_WIDTH-1:0]   shreg_q, shreg_d;
  logic                   mem_rd_q, mem_rd_d;
  logic                   m_valid_q, m_valid_d;
  logic                   m_first_q, m_first_d;
  logic                   m_last_q, m_last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

`ifdef CFG_PAUSE_EN
  localparam int PCNT_W = $clog2(PAUSE_CYCLES + 1);
  localparam logic [ADDR_W-1:0] PAUSE_ENTRY = ADDR_W'(PAUSE_IDX);
  localparam logic [PCNT_W-1:0] PAUSE_LAST  = PCNT_W'(PAUSE_CYCLES - 1);
  logic [PCNT_W-1:0]      pause_cnt_q, pause_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bcnt_d    = bcnt_q;
    shreg_d   = shreg_q;
    m_valid_d = m_valid_q;
    m_first_d = m_first_q;
    m_last_d  = m_last_q;
    done_d    = done_q;
    err_d     = err_q;
`ifdef CFG_PAUSE_EN
    pause_cnt_d = pause_cnt_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_LOAD;
      S_LOAD: begin
        shreg_d   = mem_data_i;
        bcnt_d    = '0;
        m_valid_d = 1'b1;
        m_first_d = 1'b1;
        m_last_d  = (CYCLES == 1);
        state_d   = S_SEND;
      end
      S_SEND: begin
        // A NACK outranks a simultaneous byte acceptance: the transaction is dead.
        if (i2c_nack_i) begin
          m_valid_d = 1'b0;
          m_first_d = 1'b0;
          m_last_d  = 1'b0;
          err_d     = 1'b1;
          state_d   = S_ERROR;
        end else if (m_valid_q && m_ready_i) begin
          shreg_d   = shreg_q << DATA_WIDTH;
          bcnt_d    = bcnt_q + 1'b1;
          m_first_d = 1'b0;
          m_last_d  = ((bcnt_q + 1'b1) == LAST_BYTE);
          if (bcnt_q == LAST_BYTE) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            state_d   = S_WAIT_TXN;
          end
        end
      end
      S_WAIT_TXN: begin
        if (i2c_nack_i) begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end else if (!i2c_busy_i) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_DONE;
`ifdef CFG_PAUSE_EN
          end else if (idx_q == PAUSE_ENTRY) begin
            pause_cnt_d = '0;
            state_d     = S_PAUSE;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
`ifdef CFG_PAUSE_EN
      S_PAUSE: begin
        if (pause_cnt_q == PAUSE_LAST) begin
          idx_d   = idx_q + 1'b1;
          state_d = S_READ;
        end else begin
          pause_cnt_d = pause_cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Strobe-type outputs are registered straight from the next state.
    mem_rd_d = (state_d == S_READ);
    busy_d   = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      bcnt_q    <= '0;
      shreg_q   <= '0;
      mem_rd_q  <= 1'b0;
      m_valid_q <= 1'b0;
      m_first_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef CFG_PAUSE_EN
      pause_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bcnt_q    <= bcnt_d;
      shreg_q   <= shreg_d;
      mem_rd_q  <= mem_rd_d;
      m_valid_q <= m_valid_d;
      m_first_q <= m_first_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef CFG_PAUSE_EN
      pause_cnt_q <= pause_cnt_d;
`endif
    end
  end

  // Byte lane is the top of the shift register, so it is stable until acceptance.
  assign m_data_o    = shreg_q[MEM_WIDTH-1 -: DATA_WIDTH];
  assign mem_rd_o    = mem_rd_q;
  assign mem_addr_o  = idx_q;
  assign m_valid_o   = m_valid_q;
  assign m_first_o   = m_first_q;
  assign m_last_o    = m_last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cfg_seq_loader.sv
// tb_cfg_seq_loader: directed bench for cfg_seq_loader with a 4-entry ROM, pause after entry 1.
// Works with and without CFG_PAUSE_EN; the expected pause gap follows the macro.
module tb_cfg_seq_loader;

  localparam int AW = 2;
`ifdef CFG_PAUSE_EN
  localparam int EXP_GAP = 10;
`else
  localparam int EXP_GAP = 0;
`endif

  // {first, last, byte}, worked out by hand from the ROM image
  localparam logic [9:0] EXP_SEQ [12] = '{
    {2'b10, 8'h0B}, {2'b00, 8'h24}, {2'b01, 8'hC0},
    {2'b10, 8'h0B}, {2'b00, 8'h25}, {2'b01, 8'h00},
    {2'b10, 8'h00}, {2'b00, 8'h01}, {2'b01, 8'h02},
    {2'b10, 8'hFF}, {2'b00, 8'hEE}, {2'b01, 8'h55}
  };

  logic          clk = 1'b0;
  logic          rst_i, start_i;
  logic          mem_rd_o;
  logic [AW-1:0] mem_addr_o;
  logic [23:0]   mem_data_i = '0;
  logic [7:0]    m_data_o;
  logic          m_valid_o, m_ready_i, m_first_o, m_last_o;
  logic          i2c_busy_i, i2c_nack_i;
  logic          busy_o, done_o, err_o;
  logic [2:0]    dbg_state_o;

  logic [23:0]   rom [4];
  logic [9:0]    obs_q[$];
  logic [9:0]    exp_q[$];
  logic [AW-1:0] rd_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            last1_cyc = 0;
  int            rd2_cyc = 0;
  int            busy_hold = 0;
  int            stall_left = 0;
  logic          stall_active = 1'b0;

  cfg_seq_loader #(
    .MEM_DEPTH(4), .MEM_WIDTH(24), .DATA_WIDTH(8),
    .PAUSE_IDX(1), .PAUSE_CYCLES(10)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_first_o(m_first_o), .m_last_o(m_last_o),
    .i2c_busy_i(i2c_busy_i), .i2c_nack_i(i2c_nack_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #4 clk = ~clk;

  // ROM with one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd_o) mem_data_i <= rom[mem_addr_o];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // I2C master model: decides ready at the negedge, logs handshakes that land on the next posedge.
  initial begin
    m_ready_i  = 1'b1;
    i2c_busy_i = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_i || err_o) begin
        i2c_busy_i = 1'b0;
        busy_hold  = 0;
      end else if (busy_hold > 0) begin
        busy_hold--;
        if (busy_hold == 0) i2c_busy_i = 1'b0;
      end
      m_ready_i = 1'b1;
      if (stall_left > 0 && (stall_active || (m_valid_o && m_data_o == 8'h24))) begin
        stall_active = 1'b1;
        m_ready_i    = 1'b0;
        stall_left--;
        check("stall_hold", {m_valid_o, m_first_o, m_last_o, m_data_o}, {3'b100, 8'h24});
        if (stall_left == 0) stall_active = 1'b0;
      end
      if (!rst_i && m_valid_o && m_ready_i) begin
        obs_q.push_back({m_first_o, m_last_o, m_data_o});
        if (m_first_o) i2c_busy_i = 1'b1;
        if (m_last_o) begin
          busy_hold = 2;
          if (obs_q.size() == 6) last1_cyc = cyc;
        end
      end
      if (mem_rd_o) begin
        rd_q.push_back(mem_addr_o);
        if (mem_addr_o == 2'd2) rd2_cyc = cyc;
      end
    end
  end

  // driver tasks
  task automatic pulse_start();
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 600 && !done_o; i++) @(negedge clk);
    check({tag, "_done"}, done_o, 1'b1);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_err"}, err_o, 1'b0);
  endtask

  task automatic wait_bytes(input int n);
    for (int i = 0; i < 200 && obs_q.size() < n; i++) @(posedge clk);
    check("wait_bytes", (obs_q.size() >= n), 1'b1);
  endtask

  task automatic clear_logs();
    obs_q.delete();
    rd_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"}, {busy_o, done_o, err_o, m_valid_o, mem_rd_o, m_first_o, m_last_o}, 7'b0);
    check({tag, "_addr"}, mem_addr_o, 2'd0);
    check({tag, "_data"}, m_data_o, 8'h00);
    check({tag, "_state"}, dbg_state_o, 3'd0);
  endtask

  // scoreboard: observed bytes and ROM reads against the hand-computed run
  task automatic compare_run(input string tag);
    for (int i = 0; i < 12; i++) exp_q.push_back(EXP_SEQ[i]);
    check({tag, "_nbytes"}, obs_q.size(), 12);
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++)
      check($sformatf("%s_byte%0d", tag, i), obs_q.pop_front(), exp_q.pop_front());
    check({tag, "_nreads"}, rd_q.size(), 4);
    for (int i = 0; rd_q.size() > 0; i++)
      check($sformatf("%s_rdaddr%0d", tag, i), rd_q.pop_front(), i);
    clear_logs();
  endtask

  initial begin
    rom[0] = 24'h0B24C0;
    rom[1] = 24'h0B2500;
    rom[2] = 24'h000102;
    rom[3] = 24'hFFEE55;
    rst_i = 1'b1; start_i = 1'b0; i2c_nack_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_i = 1'b0;

    // NACK outside a transaction is ignored
    @(negedge clk) i2c_nack_i = 1'b1;
    @(negedge clk) i2c_nack_i = 1'b0;
    check("idle_nack_err", err_o, 1'b0);
    check("idle_nack_busy", busy_o, 1'b0);

    // full run, ready always high
    pulse_start();
    check("run1_busy", busy_o, 1'b1);
    wait_done("run1");
    check("pause_gap", rd2_cyc - last1_cyc - 3, EXP_GAP);
    compare_run("run1");

    // restart from DONE, 5-cycle stall on 0x24, start pulse while busy
    stall_left = 5;
    pulse_start();
    check("run2_done_cleared", done_o, 1'b0);
    for (int i = 0; i < 200 && !stall_active; i++) @(posedge clk);
    pulse_start();
    wait_done("run2");
    check("run2_stall_used", stall_left, 0);
    compare_run("run2");

    // NACK while entry 2 is on the bus
    pulse_start();
    wait_bytes(7);
    @(negedge clk) i2c_nack_i = 1'b1;
    @(negedge clk) i2c_nack_i = 1'b0;
    check("nack_err", err_o, 1'b1);
    check("nack_valid", m_valid_o, 1'b0);
    check("nack_busy", busy_o, 1'b0);
    repeat (20) @(negedge clk);
    check("nack_nreads", rd_q.size(), 3);
    check("nack_err_sticky", err_o, 1'b1);
    clear_logs();
    pulse_start();
    check("restart_err_cleared", err_o, 1'b0);
    wait_done("run3");
    compare_run("run3");

    // reset in the middle of the load, then replay
    pulse_start();
`ifdef CFG_PAUSE_EN
    for (int i = 0; i < 200 && dbg_state_o != 3'd5; i++) @(negedge clk);
    check("reached_pause", dbg_state_o, 3'd5);
    repeat (3) @(negedge clk);
`else
    wait_bytes(4);
`endif
    @(negedge clk) rst_i = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    rst_i = 1'b0;
    clear_logs();
    pulse_start();
    wait_done("run4");
    compare_run("run4");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cfg_seq_loader.md
Name: cfg_seq_loader

Overview:
- Sequencer between the Si5340 configuration ROM and the byte-level I2C write master.
- On start, reads MEM_DEPTH 24-bit entries in address order and splits each into 3 bytes, MSB first.
- Each entry is presented to the I2C master as one write transaction of 3 bytes.
- Inserts the mandatory post-preamble pause (300 ms) after a configurable entry, then streams the remaining entries and reports done or error.

Parameters:
- MEM_DEPTH, 326, number of ROM entries.
- MEM_WIDTH, 24, ROM entry width.
- DATA_WIDTH, 8, byte width toward the I2C master.
- CYCLES, MEM_WIDTH/DATA_WIDTH (3), bytes per entry.
- PAUSE_IDX, 2, index of the last preamble entry; the pause follows this entry.
- PAUSE_CYCLES, 37_500_000, pause length in clk_i cycles (300 ms at 125 MHz).
- ADDR_W, $clog2(MEM_DEPTH) (9), ROM address width.

Ports:
- clk_i  in  1  system clock, 125 MHz.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  one-cycle pulse; begins a load; ignored unless in IDLE, DONE or ERROR.
- mem_rd_o  out  1  ROM read enable; data returns exactly 1 cycle later.
- mem_addr_o  out  ADDR_W  ROM address.
- mem_data_i  in  MEM_WIDTH  ROM read data.
- m_data_o  out  DATA_WIDTH  byte to the I2C master.
- m_valid_o  out  1  byte valid.
- m_ready_i  in  1  I2C master accepts the byte.
- m_first_o  out  1  byte is first of a transaction; master issues START + SLAVE_ADDR/WRITE.
- m_last_o  out  1  byte is last of a transaction; master issues STOP after it.
- i2c_busy_i  in  1  I2C master transaction in progress.
- i2c_nack_i  in  1  one-cycle pulse; slave NACK seen.
- busy_o  out  1  load in progress.
- done_o  out  1  sticky; all entries sent.
- err_o  out  1  sticky; load aborted on NACK.

Behaviour:
- Reset values: state IDLE, all outputs 0, mem_addr_o 0, entry counter 0, byte counter 0, pause counter 0.
- Reset has priority over every other event, including mid-transaction and mid-pause.
- States: IDLE, READ, LOAD, SEND, WAIT_TXN, PAUSE, DONE, ERROR.
- IDLE / DONE / ERROR + start_i: clear done_o and err_o, entry index = 0, go to READ.
- READ (1 cycle): mem_rd_o = 1, mem_addr_o = entry index. Go to LOAD.
- LOAD (1 cycle): latch mem_data_i into a shift register, byte counter = 0. Go to SEND.
- SEND: m_valid_o = 1, m_data_o = shreg[23:16].
  - m_first_o = 1 when byte counter == 0; m_last_o = 1 when byte counter == CYCLES-1.
  - m_data_o, m_first_o and m_last_o are held stable while m_valid_o && !m_ready_i.
  - On m_valid_o && m_ready_i: shift left by 8 and increment the byte counter.
  - On acceptance of the last byte: drop m_valid_o next cycle and go to WAIT_TXN.
- WAIT_TXN: wait for i2c_busy_i == 0, checked no earlier than 1 cycle after the last byte is accepted. Then:
  - index == MEM_DEPTH-1: go to DONE.
  - index == PAUSE_IDX (feature enabled): go to PAUSE.
  - otherwise: index+1, go to READ.
- PAUSE: count 0..PAUSE_CYCLES-1, then index+1, go to READ. No I2C activity during the pause.
- DONE: done_o = 1, busy_o = 0.
- busy_o = 1 in every state except IDLE, DONE and ERROR.
- NACK: i2c_nack_i in SEND or WAIT_TXN goes to ERROR the next cycle. m_valid_o is dropped immediately, err_o = 1 and stays set until the next start_i. i2c_nack_i in any other state is ignored.
- start_i while busy_o = 1 is ignored.
- End-to-end count: total bytes = CYCLES*MEM_DEPTH (978) and total transactions = MEM_DEPTH.
- Wrap-around: the entry index never exceeds MEM_DEPTH-1; no ROM read at MEM_DEPTH.

Optional Feature:
- Macro CFG_PAUSE_EN.
- Defined: PAUSE state inserted after entry PAUSE_IDX as above.
- Undefined: PAUSE state and counter are not built; WAIT_TXN after PAUSE_IDX proceeds directly to READ. Used for fast simulation and for boards with an external preamble delay.

Test Plan (MEM_DEPTH=4, PAUSE_IDX=1, PAUSE_CYCLES=10, ROM = 0x0B24C0, 0x0B2500, 0x000102, 0xFFEE55):
- Start, m_ready_i always 1, i2c_busy_i low 2 cycles after last byte -> bytes 0B,24,C0 | 0B,25,00 | 00,01,02 | FF,EE,55. first set on 0B,0B,00,FF; last set on C0,00,02,55. done_o = 1, busy_o = 0.
- Same run with CFG_PAUSE_EN -> exactly 10 idle cycles (m_valid_o = 0, mem_rd_o = 0) between WAIT_TXN exit after entry 1 and the ROM read of entry 2. Without the macro, the gap is 0.
- m_ready_i low 5 cycles on byte 0x24 -> m_data_o holds 0x24 with m_valid_o = 1 throughout; no byte skipped or duplicated.
- i2c_nack_i pulse during entry 2 -> err_o = 1, m_valid_o = 0 next cycle, no further ROM reads. A new start_i clears err_o and restarts at address 0.
- rst_i asserted during PAUSE cycle 4 -> all outputs 0 the next cycle. A later start_i replays from entry 0.
- start_i pulsed while busy_o = 1 -> ignored; byte sequence unchanged.
